// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for alu_pipe.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_NOR = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8
    } opcode_t;

    localparam int NUM_FLAGS = 5;
    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_NEG   = 3;
    localparam int FLG_ERR   = 4;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per clock after start.
module alu_mul_iter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    logic          busy;
    logic [CW-1:0] count;
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   mplier;

    // The final step's sum is exposed directly so the caller can capture it on the same edge.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign done     = busy && (count == CW'(DATA_WIDTH - 1));
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            mcand  <= {{W{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and iterative multiply.
// Define ALU_SAT_EN to saturate ADD/SUB results instead of wrapping.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SHW        = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] ina,
    input  logic [DATA_WIDTH-1:0] inb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic [4:0]            flags
);

    localparam int W = DATA_WIDTH;

    state_t               state;
    logic                 fire;
    logic                 load;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*W-1:0]       product;
    logic [W:0]           sum;
    logic [W:0]           diff;
    logic                 shift_oob;
    logic [W-1:0]         alu_res;
    logic                 alu_carry;
    logic                 alu_ovf;
    logic                 alu_err;
    logic [W-1:0]         load_res;
    logic [W-1:0]         load_hi;
    logic [NUM_FLAGS-1:0] load_flags;

    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign fire      = in_valid && in_ready;
    assign mul_start = fire && (opcode == OP_MUL);
    assign load      = (fire && (opcode != OP_MUL)) || mul_done;

    assign sum       = {1'b0, ina} + {1'b0, inb};
    assign diff      = {1'b0, ina} - {1'b0, inb};
    assign shift_oob = (inb >= W'(DATA_WIDTH));

    alu_mul_iter #(.DATA_WIDTH(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (ina),
        .b       (inb),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res   = sum[W-1:0];
                alu_carry = sum[W];
                alu_ovf   = (ina[W-1] == inb[W-1]) && (sum[W-1] != ina[W-1]);
`ifdef ALU_SAT_EN
                if (sum[W]) alu_res = '1;
`endif
            end
            OP_SUB: begin
                alu_res   = diff[W-1:0];
                alu_carry = diff[W];
                alu_ovf   = (ina[W-1] != inb[W-1]) && (diff[W-1] != ina[W-1]);
`ifdef ALU_SAT_EN
                if (diff[W]) alu_res = '0;
`endif
            end
            OP_AND: alu_res = ina & inb;
            OP_OR:  alu_res = ina | inb;
            OP_NOR: alu_res = ~(ina | inb);
            OP_XOR: alu_res = ina ^ inb;
            OP_SHL: alu_res = shift_oob ? '0 : (ina << inb[SHW-1:0]);
            OP_SHR: alu_res = shift_oob ? '0 : (ina >> inb[SHW-1:0]);
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // In MUL the only possible load is the finished product; otherwise the ALU path.
    always_comb begin
        load_flags = '0;
        if (state == ST_MUL) begin
            load_res              = product[W-1:0];
            load_hi               = product[2*W-1:W];
            load_flags[FLG_ZERO]  = (product == '0);
            load_flags[FLG_NEG]   = product[2*W-1];
        end else begin
            load_res              = alu_res;
            load_hi               = '0;
            load_flags[FLG_ZERO]  = !alu_err && (alu_res == '0);
            load_flags[FLG_NEG]   = alu_res[W-1];
            load_flags[FLG_CARRY] = alu_carry;
            load_flags[FLG_OVF]   = alu_ovf;
            load_flags[FLG_ERR]   = alu_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (state == ST_IDLE) begin
            if (mul_start) state <= ST_MUL;
        end else if (mul_done) begin
            state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= load_res;
            result_hi <= load_hi;
            flags     <= load_flags;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised scoreboard bench for alu_pipe with directed handshake, latency and reset cases.
module tb_alu_pipe;

    localparam int N   = 8;
    localparam int MOD = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [N-1:0] ina;
    logic [N-1:0] inb;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [N-1:0] result_hi;
    logic [4:0]   flags;

    typedef struct {
        logic [N-1:0] res;
        logic [N-1:0] hi;
        logic [4:0]   fl;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    bit   rand_ready = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_pipe #(.DATA_WIDTH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .ina       (ina),
        .inb       (inb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t m;
        int r, hi, sa, sb, sr, p;
        bit c, o, e, z, ng;
        r = 0; hi = 0; c = 0; o = 0; e = 0;
        sa = (a >= MOD/2) ? a - MOD : a;
        sb = (b >= MOD/2) ? b - MOD : b;
        case (op)
            0: begin
                r  = a + b;
                c  = (r >= MOD);
                r  = r % MOD;
                sr = sa + sb;
                o  = (sr > MOD/2 - 1) || (sr < -(MOD/2));
`ifdef ALU_SAT_EN
                if (c) r = MOD - 1;
`endif
            end
            1: begin
                c  = (a < b);
                r  = (a - b + MOD) % MOD;
                sr = sa - sb;
                o  = (sr > MOD/2 - 1) || (sr < -(MOD/2));
`ifdef ALU_SAT_EN
                if (c) r = 0;
`endif
            end
            2: r = a & b;
            3: r = a | b;
            4: r = (~(a | b)) & (MOD - 1);
            5: r = a ^ b;
            6: r = (b >= N) ? 0 : (a << b) % MOD;
            7: r = (b >= N) ? 0 : (a >> b);
            8: begin
                p  = a * b;
                r  = p % MOD;
                hi = p / MOD;
            end
            default: e = 1;
        endcase
        z  = !e && (r == 0) && (hi == 0);
        ng = (op == 8) ? (hi >= MOD/2) : (r >= MOD/2);
        m.res = N'(r);
        m.hi  = N'(hi);
        m.fl  = {e, ng, o, c, z};
        m.due = 0;
        return m;
    endfunction

    // Starts and ends on a falling edge; pushes the expectation only once acceptance is certain.
    task automatic applyStimulus(input int op, input int a, input int b);
        int   waited;
        exp_t e;
        waited   = 0;
        opcode   = 4'(op);
        ina      = N'(a);
        inb      = N'(b);
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            @(negedge clk);
            return;
        end
        e     = model(op, a, b);
        e.due = cyc + ((op == 8) ? N + 1 : 1);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 4'($urandom);
        ina      = N'($urandom);
        inb      = N'($urandom);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every presented cycle, so held results must also stay stable.
    initial begin
        exp_t e;
        bit   prev_v;
        bit   prev_t;
        prev_v = 1'b0;
        prev_t = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_v = 1'b0;
                prev_t = 1'b0;
            end else begin
                if (out_valid) begin
                    if (sbq.size() == 0) begin
                        checkOutput("unexpected_out", 32'(out_valid), 32'd0);
                    end else begin
                        e = sbq[0];
                        if (!prev_v || prev_t) checkOutput("latency", 32'(cyc), 32'(e.due));
                        checkOutput("result", 32'(result), 32'(e.res));
                        checkOutput("result_hi", 32'(result_hi), 32'(e.hi));
                        checkOutput("flags", 32'(flags), 32'(e.fl));
                        if (out_ready) void'(sbq.pop_front());
                    end
                end
                prev_v = out_valid;
                prev_t = out_valid && out_ready;
            end
        end
    end

    initial begin
        int op, a, b, w;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        opcode    = '0;
        ina       = '0;
        inb       = '0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_result_hi", 32'(result_hi), 32'd0);
        checkOutput("rst_flags", 32'(flags), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("ready_after_reset", 32'(in_ready), 32'd1);
        @(negedge clk);

        applyStimulus(0, 'hF0, 'h20);
        applyStimulus(1, 'h05, 'h05);
        applyStimulus(1, 'h80, 'h01);
        applyStimulus(8, 13, 11);
        for (int i = 0; i < N; i++) begin
            #1;
            checkOutput("busy_in_mul", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        applyStimulus(8, 'hFF, 'hFF);
        @(negedge clk);
        applyStimulus(12, 'h33, 'h44);
        applyStimulus(6, 'h5A, 9);
        applyStimulus(6, 'h80, 1);
        @(negedge clk);

        out_ready = 1'b0;
        applyStimulus(5, 'hAA, 'h0F);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        applyStimulus(2, 'h3C, 'h0F);
        @(negedge clk);

        applyStimulus(8, 200, 100);
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_result", 32'(result), 32'd0);
        checkOutput("abort_flags", 32'(flags), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("ready_after_abort", 32'(in_ready), 32'd1);
        repeat (15) @(negedge clk);

        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            op = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
            a  = $urandom_range(0, MOD - 1);
            b  = (op == 6 || op == 7) ? int'($urandom_range(0, 11)) : int'($urandom_range(0, MOD - 1));
            applyStimulus(op, a, b);
        end

        rand_ready = 1'b0;
        out_ready  = 1'b1;
        w = 0;
        while (sbq.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("drain", 32'(sbq.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
